// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART RX frame controller.
// The parser state and the error codes reported to the FFT input sequencer live here.
package uart_frame_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LEN,
        PAYLOAD,
        CSUM
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_LEN,
        ERR_CSUM,
        ERR_TIMEOUT
    } err_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap timer: counts idle cycles while enabled and flags the cycle in which
// the TIMEOUT-th consecutive idle cycle elapses, so the abort registers TIMEOUT cycles after the last byte.
module uart_gap_timer #(
    parameter int TIMEOUT = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expired_o
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [TW-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst || !en || clr) begin
            cnt_reg <= '0;
        end else if (cnt_reg != TW'(TIMEOUT - 1)) begin
            cnt_reg <= cnt_reg + TW'(1);
        end
    end

    // A byte arriving in the expiry cycle suppresses the flag.
    assign expired_o = en && !clr && (cnt_reg == TW'(TIMEOUT - 1));

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frame parser between the UART RX byte stream and the word assembler:
// [SYNC][LEN][LEN*DEPTH payload][XOR checksum], forwarding payload and flushing on error.
module uart_rx_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter int               MAX_WORDS = 64,
    parameter int               TIMEOUT   = 50000,
    parameter logic [WIDTH-1:0] SYNC_BYTE = WIDTH'(SYNC_BYTE_DEFAULT)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             rx_valid_i,
    input  logic [WIDTH-1:0]                 rx_data_i,
    output logic                             asm_push_o,
    output logic [WIDTH-1:0]                 asm_data_o,
    output logic                             asm_flush_o,
    output logic                             frame_start_o,
    output logic                             frame_done_o,
    output logic                             frame_err_o,
    output logic [1:0]                       err_code_o,
    output logic [$clog2(MAX_WORDS+1)-1:0]   frame_len_o,
    output logic                             busy_o
);

    localparam int LW = $clog2(MAX_WORDS + 1);
    localparam int CW = $clog2(MAX_WORDS * DEPTH + 1);

    state_t           state_reg,    state_next;
    err_t             err_code_reg, err_code_next;
    logic [WIDTH-1:0] csum_reg,     csum_next;
    logic [CW-1:0]    byte_cnt_reg, byte_cnt_next;
    logic [LW-1:0]    len_reg,      len_next;
    logic [WIDTH-1:0] data_reg,     data_next;
    logic             push_reg,     push_next;
    logic             flush_reg,    flush_next;
    logic             start_reg,    start_next;
    logic             done_reg,     done_next;
    logic             err_reg,      err_next;

    logic             timer_expired;
    logic             abort;
    err_t             abort_code;
    logic [CW-1:0]    frame_bytes;
    logic             len_bad;

    uart_gap_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_gap_timer (
        .clk       (clk),
        .rst       (rst),
        .en        (state_reg != IDLE),
        .clr       (rx_valid_i),
        .expired_o (timer_expired)
    );

    assign frame_bytes = CW'(len_reg) * CW'(DEPTH);
    assign len_bad     = (rx_data_i == '0) || (32'(rx_data_i) > 32'(MAX_WORDS));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            err_code_reg <= ERR_NONE;
            csum_reg     <= '0;
            byte_cnt_reg <= '0;
            len_reg      <= '0;
            data_reg     <= '0;
            push_reg     <= 1'b0;
            flush_reg    <= 1'b0;
            start_reg    <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            err_code_reg <= err_code_next;
            csum_reg     <= csum_next;
            byte_cnt_reg <= byte_cnt_next;
            len_reg      <= len_next;
            data_reg     <= data_next;
            push_reg     <= push_next;
            flush_reg    <= flush_next;
            start_reg    <= start_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        err_code_next = err_code_reg;
        csum_next     = csum_reg;
        byte_cnt_next = byte_cnt_reg;
        len_next      = len_reg;
        data_next     = data_reg;
        push_next     = 1'b0;
        flush_next    = 1'b0;
        start_next    = 1'b0;
        done_next     = 1'b0;
        err_next      = 1'b0;
        abort         = 1'b0;
        abort_code    = ERR_NONE;

        case (state_reg)
            IDLE: begin
                if (rx_valid_i && rx_data_i == SYNC_BYTE) begin
                    state_next = LEN;
                end
            end
            LEN: begin
                if (rx_valid_i) begin
                    if (len_bad) begin
                        abort      = 1'b1;
                        abort_code = ERR_LEN;
                    end else begin
                        len_next      = LW'(rx_data_i);
                        csum_next     = rx_data_i;
                        byte_cnt_next = '0;
                        err_code_next = ERR_NONE;
                        start_next    = 1'b1;
                        state_next    = PAYLOAD;
                    end
                end else if (timer_expired) begin
                    abort      = 1'b1;
                    abort_code = ERR_TIMEOUT;
                end
            end
            PAYLOAD: begin
                if (rx_valid_i) begin
                    push_next     = 1'b1;
                    data_next     = rx_data_i;
                    csum_next     = csum_reg ^ rx_data_i;
                    byte_cnt_next = byte_cnt_reg + CW'(1);
                    if (byte_cnt_next == frame_bytes) begin
                        state_next = CSUM;
                    end
                end else if (timer_expired) begin
                    abort      = 1'b1;
                    abort_code = ERR_TIMEOUT;
                end
            end
            CSUM: begin
                if (rx_valid_i) begin
                    if (rx_data_i == csum_reg) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        abort      = 1'b1;
                        abort_code = ERR_CSUM;
                    end
                end else if (timer_expired) begin
                    abort      = 1'b1;
                    abort_code = ERR_TIMEOUT;
                end
            end
            default: state_next = IDLE;
        endcase

        // Any abort discards the assembler's partial word alongside the error pulse.
        if (abort) begin
            state_next    = IDLE;
            flush_next    = 1'b1;
            err_next      = 1'b1;
            err_code_next = abort_code;
        end
    end

    assign asm_push_o    = push_reg;
    assign asm_data_o    = data_reg;
    assign asm_flush_o   = flush_reg;
    assign frame_start_o = start_reg;
    assign frame_done_o  = done_reg;
    assign frame_err_o   = err_reg;
    assign err_code_o    = err_code_reg;
    assign frame_len_o   = len_reg;
    assign busy_o        = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Self-checking bench for uart_rx_frame_ctrl: directed frames plus randomized frames, with
// expectations derived from the intended role of every byte the generator sends.
module tb_uart_rx_frame_ctrl;

    localparam int WIDTH     = 8;
    localparam int DEPTH     = 4;
    localparam int MAX_WORDS = 64;
    localparam int TIMEOUT   = 16;
    localparam int LW        = $clog2(MAX_WORDS + 1);
    localparam logic [7:0] SYNC = 8'hA5;

    typedef enum int {R_JUNK, R_SYNC, R_LEN_OK, R_LEN_BAD, R_PAY, R_CSUM_OK, R_CSUM_BAD} role_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             rx_valid;
    logic [WIDTH-1:0] rx_data;
    logic             asm_push;
    logic [WIDTH-1:0] asm_data;
    logic             asm_flush;
    logic             frame_start;
    logic             frame_done;
    logic             frame_err;
    logic [1:0]       err_code;
    logic [LW-1:0]    frame_len;
    logic             busy;

    int               vectors     = 0;
    int               miscompares = 0;
    logic [1:0]       cur_code;
    logic [LW-1:0]    cur_len;
    logic [7:0]       pay_q[$];

    uart_rx_frame_ctrl #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .MAX_WORDS (MAX_WORDS),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_valid_i    (rx_valid),
        .rx_data_i     (rx_data),
        .asm_push_o    (asm_push),
        .asm_data_o    (asm_data),
        .asm_flush_o   (asm_flush),
        .frame_start_o (frame_start),
        .frame_done_o  (frame_done),
        .frame_err_o   (frame_err),
        .err_code_o    (err_code),
        .frame_len_o   (frame_len),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input bit push, input logic [7:0] data, input bit flush,
                              input bit start, input bit done, input bit err, input bit bsy);
        chk("asm_push", 32'(asm_push), 32'(push));
        if (push) chk("asm_data", 32'(asm_data), 32'(data));
        chk("asm_flush", 32'(asm_flush), 32'(flush));
        chk("frame_start", 32'(frame_start), 32'(start));
        chk("frame_done", 32'(frame_done), 32'(done));
        chk("frame_err", 32'(frame_err), 32'(err));
        chk("err_code", 32'(err_code), 32'(cur_code));
        chk("frame_len", 32'(frame_len), 32'(cur_len));
        chk("busy", 32'(busy), 32'(bsy));
    endtask

    // One clock: present inputs, let the edge take them, then sample 1 time unit later.
    task automatic step(input bit v, input logic [7:0] d);
        rx_valid = v;
        rx_data  = d;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic send(input logic [7:0] d, input role_t r);
        step(1'b1, d);
        case (r)
            R_JUNK:     check_outs(0, 8'h00, 0, 0, 0, 0, 0);
            R_SYNC:     check_outs(0, 8'h00, 0, 0, 0, 0, 1);
            R_LEN_OK: begin
                cur_code = 2'd0;
                cur_len  = LW'(d);
                check_outs(0, 8'h00, 0, 1, 0, 0, 1);
            end
            R_LEN_BAD: begin
                cur_code = 2'd1;
                check_outs(0, 8'h00, 1, 0, 0, 1, 0);
            end
            R_PAY:      check_outs(1, d, 0, 0, 0, 0, 1);
            R_CSUM_OK:  check_outs(0, 8'h00, 0, 0, 1, 0, 0);
            default: begin
                cur_code = 2'd2;
                check_outs(0, 8'h00, 1, 0, 0, 1, 0);
            end
        endcase
    endtask

    task automatic idle(input int n, input bit in_frame);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 8'h00);
            check_outs(0, 8'h00, 0, 0, 0, 0, in_frame);
        end
    endtask

    // Silence long enough to expire the gap timer: error lands exactly TIMEOUT cycles after the last byte.
    task automatic expect_timeout();
        idle(TIMEOUT - 1, 1'b1);
        step(1'b0, 8'h00);
        cur_code = 2'd3;
        check_outs(0, 8'h00, 1, 0, 0, 1, 0);
    endtask

    task automatic fill_random(input int words);
        pay_q.delete();
        for (int i = 0; i < words * DEPTH; i++) pay_q.push_back(8'($urandom));
    endtask

    task automatic send_junk(input int n);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            d = 8'($urandom);
            if (d == SYNC) d = 8'h00;
            send(d, R_JUNK);
        end
    endtask

    // Full frame from pay_q; csum_mask != 0 corrupts the checksum; gap_at >= 0 inserts
    // the longest idle gap that must not time out before that payload byte.
    task automatic frame(input logic [7:0] len_b, input logic [7:0] csum_mask, input int gap_at);
        logic [7:0] cs;
        cs = len_b;
        foreach (pay_q[i]) cs = cs ^ pay_q[i];
        send(SYNC, R_SYNC);
        send(len_b, R_LEN_OK);
        foreach (pay_q[i]) begin
            if (i == gap_at) idle(TIMEOUT - 1, 1'b1);
            send(pay_q[i], R_PAY);
        end
        send(cs ^ csum_mask, (csum_mask == 8'h00) ? R_CSUM_OK : R_CSUM_BAD);
    endtask

    initial begin
        int kind;
        int words;
        int cut;
        logic [7:0] bad_len;

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        cur_code = 2'd0;
        cur_len  = '0;

        // Reset held with live traffic on the RX side.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, (i == 1) ? SYNC : 8'($urandom));
            check_outs(0, 8'h00, 0, 0, 0, 0, 0);
        end
        rst = 1'b0;
        idle(2, 1'b0);
        $display("reset: outputs checked");

        // Good frame A5 02 01..08 0A, back to back.
        pay_q.delete();
        for (int i = 1; i <= 8; i++) pay_q.push_back(8'(i));
        frame(8'h02, 8'h00, -1);
        $display("frame: good len 2");

        // Same frame with the checksum off by one bit.
        frame(8'h02, 8'h01, -1);
        $display("frame: bad checksum len 2");

        // Illegal lengths: zero and one above the maximum.
        send(SYNC, R_SYNC);
        send(8'h00, R_LEN_BAD);
        send(SYNC, R_SYNC);
        send(8'(MAX_WORDS + 1), R_LEN_BAD);
        $display("frame: bad lengths 0 and %0d", MAX_WORDS + 1);

        // Timeout mid-payload.
        send(SYNC, R_SYNC);
        send(8'h02, R_LEN_OK);
        send(8'h11, R_PAY);
        send(8'h22, R_PAY);
        send(8'h33, R_PAY);
        expect_timeout();
        $display("frame: timeout after 3 payload bytes");

        // Resync past leading junk; SYNC inside the payload is data.
        send(8'h00, R_JUNK);
        send(8'hFF, R_JUNK);
        send(8'h55, R_JUNK);
        pay_q.delete();
        pay_q.push_back(8'hA5);
        pay_q.push_back(8'hB6);
        pay_q.push_back(8'hC7);
        pay_q.push_back(8'hD8);
        frame(8'h01, 8'h00, -1);
        $display("frame: resync with embedded sync byte");

        // Reset mid-payload aborts silently, then a fresh frame passes.
        send(SYNC, R_SYNC);
        send(8'h01, R_LEN_OK);
        send(8'hA5, R_PAY);
        send(8'hB6, R_PAY);
        rst = 1'b1;
        step(1'b1, 8'hC7);
        cur_code = 2'd0;
        cur_len  = '0;
        check_outs(0, 8'h00, 0, 0, 0, 0, 0);
        rst = 1'b0;
        frame(8'h01, 8'h00, -1);
        $display("frame: reset mid-payload then good frame");

        // Largest legal frame, with a just-under-timeout gap in the middle.
        fill_random(MAX_WORDS);
        frame(8'(MAX_WORDS), 8'h00, 100);
        $display("frame: max length %0d with long gap", MAX_WORDS);

        // Randomized frames of all kinds.
        for (int n = 0; n < 30; n++) begin
            send_junk($urandom_range(0, 3));
            kind  = $urandom_range(0, 4);
            words = ($urandom_range(0, 7) == 0) ? MAX_WORDS : $urandom_range(1, 6);
            fill_random(words);
            case (kind)
                0: frame(8'(words), 8'h00, -1);
                1: frame(8'(words), 8'($urandom_range(1, 255)), -1);
                2: begin
                    bad_len = ($urandom_range(0, 1) == 0) ? 8'h00
                                                          : 8'($urandom_range(MAX_WORDS + 1, 255));
                    send(SYNC, R_SYNC);
                    send(bad_len, R_LEN_BAD);
                end
                3: begin
                    cut = $urandom_range(0, words * DEPTH + 1);
                    send(SYNC, R_SYNC);
                    if (cut > 0) begin
                        send(8'(words), R_LEN_OK);
                        for (int i = 0; i < cut - 1; i++) send(pay_q[i], R_PAY);
                    end
                    expect_timeout();
                end
                default: frame(8'(words), 8'h00, $urandom_range(0, words * DEPTH - 1));
            endcase
            $display("random frame %0d: kind %0d words %0d", n, kind, words);
        end

        idle(3, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
